// File: rtl/pic_pkg.sv
// Shared definitions for the rotating-priority interrupt arbiter: FSM states,
// default channel count and small integer helpers used for parameter sizing.
package pic_pkg;

  localparam int PIC_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2
  } pic_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'sd1 << res) < value) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

  // Distance of a level from the current top priority; 0 means highest.
  function automatic int prio_rank(input int lvl, input int lowest, input int n);
    return (lvl - lowest - 32'sd1 + 32'sd2 * n) % n;
  endfunction

endpackage

// File: rtl/pic_rot_pick.sv
// Rotating find-first: returns the highest-priority set bit of a request
// vector, where priority starts at (lowest+1) and descends with wrap-around.
module pic_rot_pick
  import pic_pkg::*;
#(
  parameter int N   = PIC_N_DEFAULT,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] lowest_i,
  output logic           found_o,
  output logic [IDW-1:0] id_o
);

  // Walk the levels in priority order; only the first hit is recorded.
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    logic           hit;
    sum     = 0;
    idx     = {IDW{1'b0}};
    hit     = 1'b0;
    found_o = 1'b0;
    id_o    = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum     = int'(lowest_i) + 32'sd1 + k;
      idx     = IDW'((sum >= N) ? (sum - N) : sum);
      hit     = req_i[idx] & ~found_o;
      found_o = found_o | req_i[idx];
      id_o    = hit ? idx : id_o;
    end
  end

endmodule

// File: rtl/pic_prio_arbiter.sv
// Priority interrupt arbiter with rotating priority, in-service tracking,
// two-strobe acknowledge sequence and normal/specific/automatic EOI.
module pic_prio_arbiter
  import pic_pkg::*;
#(
  parameter int  N       = PIC_N_DEFAULT,
  parameter int  VBASE_W = 5,
  localparam int IDW     = clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           irr,
  input  logic [N-1:0]           imr,
  input  logic                   fn,
  input  logic                   ar,
  input  logic                   eoi,
  input  logic                   seoi,
  input  logic [IDW-1:0]         seoi_lvl,
  input  logic                   rot_eoi,
  input  logic                   inta,
  input  logic [VBASE_W-1:0]     vbase,
  output logic [N-1:0]           isr,
  output logic                   isprior,
  output logic [VBASE_W+IDW-1:0] vec,
  output logic                   vec_vld
);

  localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] SPUR_ID  = IDW'(N - 1);

  pic_state_e             state_q;
  logic [N-1:0]           isr_q, isr_d;
  logic [IDW-1:0]         lowest_q, lowest_d;
  logic [IDW-1:0]         id_q;
  logic                   spur_q;
  logic                   isprior_q;
  logic                   vec_vld_q;
  logic [VBASE_W+IDW-1:0] vec_q;

  logic [N-1:0]   cand_req_s;
  logic           cand_found_s, isr_found_s, qualify_s;
  logic [IDW-1:0] cand_id_s, isr_id_s, clr_lvl_s;
  logic           eoi_hit_s, ar_hit_s;
  logic [N-1:0]   eoi_clr_s, ack_set_s, ar_clr_s;

  // Fully nested mode lets an in-service level re-request at its own priority.
  assign cand_req_s = irr & ~imr & (fn ? {N{1'b1}} : ~isr_q);

  pic_rot_pick #(.N(N), .IDW(IDW)) u_pick_cand (
    .req_i    (cand_req_s),
    .lowest_i (lowest_q),
    .found_o  (cand_found_s),
    .id_o     (cand_id_s)
  );

  pic_rot_pick #(.N(N), .IDW(IDW)) u_pick_isr (
    .req_i    (isr_q),
    .lowest_i (lowest_q),
    .found_o  (isr_found_s),
    .id_o     (isr_id_s)
  );

  assign qualify_s = cand_found_s &&
                     (!isr_found_s ||
                      (prio_rank(int'(cand_id_s), int'(lowest_q), N) <=
                       prio_rank(int'(isr_id_s), int'(lowest_q), N)));

  assign clr_lvl_s = seoi ? seoi_lvl : isr_id_s;
  assign eoi_hit_s = eoi && (isr_q != {N{1'b0}}) && (int'(clr_lvl_s) < N);
  assign eoi_clr_s = eoi_hit_s ? (ONE_HOT0 << clr_lvl_s) : {N{1'b0}};
  assign ack_set_s = ((state_q == ST_REQ) && inta && qualify_s) ?
                     (ONE_HOT0 << cand_id_s) : {N{1'b0}};
  assign ar_hit_s  = (state_q == ST_ACK1) && inta && ar && !spur_q;
  assign ar_clr_s  = ar_hit_s ? (ONE_HOT0 << id_q) : {N{1'b0}};

  // The EOI clear is applied first so a same-cycle acknowledge still lands.
  assign isr_d = (isr_q & ~eoi_clr_s & ~ar_clr_s) | ack_set_s;

  // Auto-EOI rotation takes precedence over an EOI rotation in the same cycle.
  always_comb begin
    lowest_d = lowest_q;
    if (ar_hit_s) begin
      lowest_d = id_q;
    end else if (eoi_hit_s && rot_eoi) begin
      lowest_d = clr_lvl_s;
    end else begin
      lowest_d = lowest_q;
    end
  end

  // Acknowledge sequencer plus all registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      isr_q     <= {N{1'b0}};
      lowest_q  <= SPUR_ID;
      id_q      <= {IDW{1'b0}};
      spur_q    <= 1'b0;
      isprior_q <= 1'b0;
      vec_q     <= {(VBASE_W+IDW){1'b0}};
      vec_vld_q <= 1'b0;
    end else begin
      isr_q     <= isr_d;
      lowest_q  <= lowest_d;
      vec_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (qualify_s) begin
            state_q   <= ST_REQ;
            isprior_q <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            isprior_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (inta) begin
            id_q      <= qualify_s ? cand_id_s : SPUR_ID;
            spur_q    <= !qualify_s;
            isprior_q <= 1'b0;
            state_q   <= ST_ACK1;
          end else if (!qualify_s) begin
            isprior_q <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            isprior_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_ACK1: begin
          if (inta) begin
            vec_q     <= {vbase, id_q};
            vec_vld_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            state_q   <= ST_ACK1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          isprior_q <= 1'b0;
        end
      endcase
    end
  end

  assign isr     = isr_q;
  assign isprior = isprior_q;
  assign vec     = vec_q;
  assign vec_vld = vec_vld_q;

endmodule

// File: tb/tb_pic_prio_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// behavioural model of the rotating-priority interrupt controller.
module tb_pic_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr, imr;
  logic       fn, ar, eoi, seoi, rot_eoi, inta;
  logic [2:0] seoi_lvl;
  logic [4:0] vbase;
  logic [7:0] isr;
  logic       isprior;
  logic [7:0] vec;
  logic       vec_vld;

  logic [15:0] irr16, imr16, isr16;
  logic [3:0]  seoi_lvl16;
  logic        isprior16, vec_vld16;
  logic [8:0]  vec16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pic_prio_arbiter #(.N(8), .VBASE_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .fn(fn), .ar(ar),
    .eoi(eoi), .seoi(seoi), .seoi_lvl(seoi_lvl), .rot_eoi(rot_eoi),
    .inta(inta), .vbase(vbase), .isr(isr), .isprior(isprior),
    .vec(vec), .vec_vld(vec_vld)
  );

  pic_prio_arbiter #(.N(16), .VBASE_W(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .irr(irr16), .imr(imr16), .fn(fn), .ar(ar),
    .eoi(eoi), .seoi(seoi), .seoi_lvl(seoi_lvl16), .rot_eoi(rot_eoi),
    .inta(inta), .vbase(vbase), .isr(isr16), .isprior(isprior16),
    .vec(vec16), .vec_vld(vec_vld16)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irr = 8'h00; imr = 8'h00; fn = 1'b0; ar = 1'b0;
    eoi = 1'b0; seoi = 1'b0; seoi_lvl = 3'd0; rot_eoi = 1'b0; inta = 1'b0;
    vbase = 5'h15; irr16 = 16'h0000; imr16 = 16'h0000; seoi_lvl16 = 4'd0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Drives a request through both acknowledge strobes, bounding the wait.
  task automatic service8(input logic [7:0] v);
    int n;
    irr = v;
    n = 0;
    while (isprior !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    checks++;
    if (isprior !== 1'b1) begin
      errors++;
      $display("FAIL service_wait isprior got %0b want 1", isprior);
    end
    inta = 1'b1; cyc(); inta = 1'b0; cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    irr = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({isr, isprior, vec, vec_vld} !== 18'd0) begin
      errors++;
      $display("FAIL reset_idle got isr=%h isprior=%b vec=%h vld=%b want all 0", isr, isprior, vec, vec_vld);
    end
    service8(8'h04);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({isr, isprior, vec, vec_vld} !== 18'd0) begin
      errors++;
      $display("FAIL reset_async got isr=%h isprior=%b vec=%h vld=%b want all 0", isr, isprior, vec, vec_vld);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    irr = 8'h04;
    cyc();
    checks++;
    if (isprior !== 1'b1) begin errors++; $display("FAIL basic_isprior got %b want 1", isprior); end
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (isr !== 8'h04 || isprior !== 1'b0) begin
      errors++; $display("FAIL basic_ack1 got isr=%h isprior=%b want 04 0", isr, isprior);
    end
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (vec_vld !== 1'b1 || vec !== 8'hAA) begin
      errors++; $display("FAIL basic_vec got vld=%b vec=%h want 1 aa", vec_vld, vec);
    end
    cyc();
    checks++;
    if (vec_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_pulse got %b want 0", vec_vld); end
    irr = 8'h00;
  endtask

  task automatic test_fully_nested();
    do_reset();
    service8(8'h04);
    irr = 8'h14; fn = 1'b0;
    cyc(); cyc();
    checks++;
    if (isr !== 8'h04 || isprior !== 1'b0) begin
      errors++; $display("FAIL fn0_block got isr=%h isprior=%b want 04 0", isr, isprior);
    end
    fn = 1'b1;
    cyc();
    checks++;
    if (isprior !== 1'b1) begin errors++; $display("FAIL fn1_same_level got %b want 1", isprior); end
    fn = 1'b0; irr = 8'h00;
  endtask

  task automatic test_auto_eoi();
    do_reset();
    ar = 1'b1; irr = 8'h01;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (isr !== 8'h01) begin errors++; $display("FAIL aeoi_set got %h want 01", isr); end
    inta = 1'b1; cyc(); inta = 1'b0; irr = 8'h03;
    checks++;
    if (isr !== 8'h00 || vec_vld !== 1'b1 || vec !== 8'hA8) begin
      errors++; $display("FAIL aeoi_clear got isr=%h vld=%b vec=%h want 00 1 a8", isr, vec_vld, vec);
    end
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (isr !== 8'h02) begin errors++; $display("FAIL aeoi_rotated_winner got %h want 02", isr); end
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (vec !== 8'hA9 || isr !== 8'h00) begin
      errors++; $display("FAIL aeoi_second_vec got vec=%h isr=%h want a9 00", vec, isr);
    end
    ar = 1'b0; irr = 8'h00;
  endtask

  task automatic test_spurious();
    do_reset();
    irr = 8'h20;
    cyc();
    checks++;
    if (isprior !== 1'b1) begin errors++; $display("FAIL spur_isprior got %b want 1", isprior); end
    irr = 8'h00;
    inta = 1'b1; cyc(); inta = 1'b0;
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (vec !== 8'hAF || vec_vld !== 1'b1 || isr !== 8'h00) begin
      errors++; $display("FAIL spur_vec got vec=%h vld=%b isr=%h want af 1 00", vec, vec_vld, isr);
    end
  endtask

  task automatic test_eoi();
    do_reset();
    service8(8'h08);
    service8(8'h02);
    checks++;
    if (isr !== 8'h0A) begin errors++; $display("FAIL eoi_setup got %h want 0a", isr); end
    eoi = 1'b1; seoi = 1'b0;
    cyc(); eoi = 1'b0;
    checks++;
    if (isr !== 8'h08) begin errors++; $display("FAIL eoi_normal got %h want 08", isr); end
    eoi = 1'b1; seoi = 1'b1; seoi_lvl = 3'd3; rot_eoi = 1'b1;
    cyc(); eoi = 1'b0; seoi = 1'b0; rot_eoi = 1'b0;
    checks++;
    if (isr !== 8'h00) begin errors++; $display("FAIL eoi_specific got %h want 00", isr); end
    irr = 8'h11;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (vec !== 8'hAC || vec_vld !== 1'b1) begin
      errors++; $display("FAIL eoi_rotate_prio got vec=%h vld=%b want ac 1", vec, vec_vld);
    end
    irr = 8'h00;
  endtask

  task automatic test_reset_ack1_n16();
    int seen;
    do_reset();
    irr16 = 16'h0100;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (isr16 !== 16'h0100) begin errors++; $display("FAIL n16_ack got %h want 0100", isr16); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({isr16, isprior16, vec16, vec_vld16} !== 27'd0) begin
      errors++; $display("FAIL n16_reset_outputs got isr=%h isprior=%b vec=%h vld=%b want all 0", isr16, isprior16, vec16, vec_vld16);
    end
    irr16 = 16'h0000;
    cyc();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      inta = (i % 2 == 0);
      cyc();
      if (vec_vld16 === 1'b1) seen++;
    end
    inta = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL n16_no_vld got %0d pulses want 0", seen); end
    irr16 = 16'h0100;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    inta = 1'b1; cyc(); inta = 1'b0;
    checks++;
    if (vec16 !== 9'h158 || vec_vld16 !== 1'b1 || isr16 !== 16'h0100) begin
      errors++; $display("FAIL n16_resume got vec=%h vld=%b isr=%h want 158 1 0100", vec16, vec_vld16, isr16);
    end
    irr16 = 16'h0000;
  endtask

  function automatic int m_pick(input logic [7:0] v, input int low);
    int lvl;
    for (int k = 1; k <= 8; k++) begin
      lvl = (low + k) % 8;
      if (v[lvl[2:0]]) return lvl;
    end
    return -1;
  endfunction

  function automatic int m_rank(input int lvl, input int low);
    return ((lvl - low - 1) % 8 + 8) % 8;
  endfunction

  task automatic test_random();
    logic [7:0] m_isr, n_isr, req;
    logic [7:0] m_vec;
    int m_low, n_low, m_phase, m_id, cand, hi, lvl;
    logic m_spur, m_isprior, m_vld, ok;
    do_reset();
    m_isr = 8'h00; m_low = 7; m_phase = 0; m_id = 0; m_spur = 1'b0;
    m_isprior = 1'b0; m_vld = 1'b0; m_vec = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irr = 8'($urandom_range(0, 255));
      imr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      fn = ($urandom_range(0, 3) == 0);
      ar = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      seoi = $urandom_range(0, 1);
      seoi_lvl = 3'($urandom_range(0, 7));
      rot_eoi = $urandom_range(0, 1);
      inta = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) vbase = 5'($urandom_range(0, 31));
      // Reference: qualifying candidate from the priority rules.
      req = irr & ~imr;
      if (!fn) req = req & ~m_isr;
      cand = m_pick(req, m_low);
      ok = (cand >= 0);
      for (int b = 0; b < 8; b++)
        if (ok && m_isr[b] && m_rank(b, m_low) < m_rank(cand, m_low)) ok = 1'b0;
      hi = m_pick(m_isr, m_low);
      n_isr = m_isr; n_low = m_low; m_vld = 1'b0;
      if (eoi && m_isr != 8'h00) begin
        lvl = seoi ? int'(seoi_lvl) : hi;
        n_isr[3'(lvl)] = 1'b0;
        if (rot_eoi) n_low = lvl;
      end
      if (m_phase == 0) begin
        m_isprior = ok;
        m_phase = ok ? 1 : 0;
      end else if (m_phase == 1) begin
        if (inta) begin
          m_id = ok ? cand : 7;
          m_spur = !ok;
          if (ok) n_isr[3'(cand)] = 1'b1;
          m_isprior = 1'b0; m_phase = 2;
        end else begin
          m_isprior = ok;
          m_phase = ok ? 1 : 0;
        end
      end else if (inta) begin
        m_vec = {vbase, 3'(m_id)};
        m_vld = 1'b1; m_phase = 0;
        if (ar && !m_spur) begin
          n_isr[3'(m_id)] = 1'b0;
          n_low = m_id;
        end
      end
      m_isr = n_isr; m_low = n_low;
      cyc();
      checks++;
      if (isr !== m_isr) begin errors++; $display("FAIL rand_isr cyc %0d got %h want %h", c, isr, m_isr); end
      checks++;
      if (isprior !== m_isprior) begin errors++; $display("FAIL rand_isprior cyc %0d got %b want %b", c, isprior, m_isprior); end
      checks++;
      if (vec_vld !== m_vld) begin errors++; $display("FAIL rand_vld cyc %0d got %b want %b", c, vec_vld, m_vld); end
      checks++;
      if (vec !== m_vec) begin errors++; $display("FAIL rand_vec cyc %0d got %h want %h", c, vec, m_vec); end
    end
    inta = 1'b0; eoi = 1'b0; irr = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_fully_nested();
    test_auto_eoi();
    test_spurious();
    test_eoi();
    test_reset_ack1_n16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
